// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_pkg
// Brief    : Shared types and constants for the lap stopwatch.
// Revision : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam int unsigned c_MOD10 = 10;
    localparam int unsigned c_MOD6  = 6;

endpackage
`default_nettype wire

// File: rtl/lap_stopwatch_if.sv
`default_nettype none
// ============================================================================
// Module   : lap_stopwatch_if
// Brief    : Control pulses and display/status outputs of the lap stopwatch.
// Revision : 1.0 - initial release
// ============================================================================
interface lap_stopwatch_if #(
    parameter int MIN_DIGITS = 1
);
    logic                    start_resume;
    logic                    stop;
    logic                    lap;
    logic [4*MIN_DIGITS-1:0] min;
    logic [3:0]              sec1;
    logic [3:0]              sec0;
    logic [3:0]              milSec0;
    logic                    running;
    logic                    lap_valid;
    logic                    overflow;

    modport master (
        output start_resume, stop, lap,
        input  min, sec1, sec0, milSec0, running, lap_valid, overflow
    );

    modport slave (
        input  start_resume, stop, lap,
        output min, sec1, sec0, milSec0, running, lap_valid, overflow
    );
endinterface
`default_nettype wire

// File: rtl/bcd_digit_counter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_counter
// Brief    : One modulo-MOD BCD digit with terminal-count flag.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter int MOD = 10
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic clear,
    input  wire logic en,
    output bcd_t      q,
    output logic      tc
);
    localparam bcd_t c_LAST = 4'(MOD - 1);

    bcd_t r_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_q <= '0;
        end else if (en) begin
            r_q <= (r_q == c_LAST) ? '0 : r_q + 4'd1;
        end
    end

    assign q  = r_q;
    assign tc = (r_q == c_LAST);
endmodule
`default_nettype wire

// File: rtl/lap_stopwatch.sv
`default_nettype none
// ============================================================================
// Module   : lap_stopwatch
// Brief    : BCD stopwatch with prescaled tick, lap/split hold and overflow.
// Revision : 1.0 - initial release
// ============================================================================
module lap_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV   = 10,
    parameter int MIN_DIGITS = 1,
    parameter int WRAP       = 1
) (
    input  wire logic       clk,
    input  wire logic       reset,
    lap_stopwatch_if.slave  bus
);
    localparam int NDIG = 3 + MIN_DIGITS;
    localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] c_PRESC_LAST = PW'(TICK_DIV - 1);

    state_t            r_state;
    logic [PW-1:0]     r_presc;
    logic              r_overflow;
    logic              r_lap_valid;
    logic [4*NDIG-1:0] r_lap;

    logic              w_start;
    logic              w_lap;
    logic              w_tick;
    logic              w_at_max;
    logic              w_adv;
    logic              w_clr;
    logic [NDIG-1:0]   w_en;
    logic [NDIG-1:0]   w_tc;
    bcd_t              w_q [NDIG];
    logic [4*NDIG-1:0] w_live;
    logic [4*NDIG-1:0] w_disp;

    // stop outranks start_resume, which outranks lap
    assign w_start  = bus.start_resume && !bus.stop;
    assign w_lap    = bus.lap && !bus.stop && !bus.start_resume;
    assign w_tick   = (r_state == RUN) && (r_presc == c_PRESC_LAST);
    assign w_at_max = &w_tc;
    assign w_adv    = w_tick && ((WRAP != 0) || !w_at_max);
    assign w_clr    = w_lap && (r_state == PAUSE) && !r_lap_valid;

    assign w_en[0] = w_adv;

    genvar gi;
    for (gi = 0; gi < NDIG; gi++) begin : g_digit
        localparam int M = (gi == 2) ? int'(c_MOD6) : int'(c_MOD10);
        bcd_digit_counter #(.MOD(M)) u_digit (
            .clk   (clk),
            .reset (reset),
            .clear (w_clr),
            .en    (w_en[gi]),
            .q     (w_q[gi]),
            .tc    (w_tc[gi])
        );
        assign w_live[4*gi +: 4] = w_q[gi];
    end

    for (gi = 1; gi < NDIG; gi++) begin : g_chain
        assign w_en[gi] = w_en[gi-1] && w_tc[gi-1];
    end

    always_ff @(posedge clk) begin
        if (reset || w_clr) begin
            r_presc <= '0;
        end else if (r_state == RUN) begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_start) r_state <= RUN;
                RUN: begin
                    if (bus.stop)
                        r_state <= PAUSE;
                    else if (w_tick && w_at_max && (WRAP == 0))
                        r_state <= PAUSE;
                end
                PAUSE: begin
                    if (w_start)
                        r_state <= RUN;
                    else if (w_clr)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_clr) begin
            r_overflow <= 1'b0;
        end else if (w_tick && w_at_max) begin
            r_overflow <= 1'b1;
        end
    end

    // capture uses the pre-increment live count of the lap cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lap_valid <= 1'b0;
            r_lap       <= '0;
        end else if (w_lap && r_lap_valid && (r_state != IDLE)) begin
            r_lap_valid <= 1'b0;
        end else if (w_lap && !r_lap_valid && (r_state == RUN)) begin
            r_lap_valid <= 1'b1;
            r_lap       <= w_live;
        end
    end

    assign w_disp        = r_lap_valid ? r_lap : w_live;
    assign bus.min       = w_disp[4*NDIG-1:12];
    assign bus.sec1      = w_disp[11:8];
    assign bus.sec0      = w_disp[7:4];
    assign bus.milSec0   = w_disp[3:0];
    assign bus.running   = (r_state == RUN);
    assign bus.lap_valid = r_lap_valid;
    assign bus.overflow  = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_lap_stopwatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_lap_stopwatch
// Brief    : Directed bench for lap_stopwatch (TICK_DIV=2, 1 minute digit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lap_stopwatch;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    lap_stopwatch_if #(.MIN_DIGITS(1)) if_wrap ();
    lap_stopwatch_if #(.MIN_DIGITS(1)) if_sat  ();

    lap_stopwatch #(.TICK_DIV(2), .MIN_DIGITS(1), .WRAP(1)) u_dut_wrap (
        .clk   (clk),
        .reset (reset),
        .bus   (if_wrap)
    );

    lap_stopwatch #(.TICK_DIV(2), .MIN_DIGITS(1), .WRAP(0)) u_dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (if_sat)
    );

    logic [15:0] w_dw;
    logic [15:0] w_ds;
    assign w_dw = {if_wrap.min, if_wrap.sec1, if_wrap.sec0, if_wrap.milSec0};
    assign w_ds = {if_sat.min, if_sat.sec1, if_sat.sec0, if_sat.milSec0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // one-cycle pulse on the wrap instance, optionally mirrored to the saturating one
    task automatic pulse(input logic s, input logic p, input logic l, input logic both);
        if_wrap.start_resume = s;
        if_wrap.stop         = p;
        if_wrap.lap          = l;
        if (both) begin
            if_sat.start_resume = s;
            if_sat.stop         = p;
            if_sat.lap          = l;
        end
        step(1);
        if_wrap.start_resume = 1'b0;
        if_wrap.stop         = 1'b0;
        if_wrap.lap          = 1'b0;
        if_sat.start_resume  = 1'b0;
        if_sat.stop          = 1'b0;
        if_sat.lap           = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        if_wrap.start_resume = 1'b0; if_wrap.stop = 1'b0; if_wrap.lap = 1'b0;
        if_sat.start_resume  = 1'b0; if_sat.stop  = 1'b0; if_sat.lap  = 1'b0;
        step(2);
        reset = 1'b0;

        check("rst_disp",    32'(w_dw), 32'h0000);
        check("rst_running", 32'(if_wrap.running), 32'd0);
        check("rst_lapv",    32'(if_wrap.lap_valid), 32'd0);
        check("rst_ovf",     32'(if_wrap.overflow), 32'd0);
        check("rst_sat",     32'({if_sat.running, if_sat.overflow, w_ds}), 32'h0);

        // first increment latency
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("start_running", 32'(if_wrap.running), 32'd1);
        step(1);
        check("cyc2_disp", 32'(w_dw), 32'h0000);
        step(1);
        check("cyc3_ms1", 32'(w_dw), 32'h0001);
        step(18);
        check("cyc21_s1", 32'(w_dw), 32'h0010);

        // run to 0:12.3, pause mid-tenth, resume
        step(226);
        check("at_12_3", 32'(w_dw), 32'h0123);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check("stop_disp", 32'(w_dw), 32'h0123);
        check("stop_running", 32'(if_wrap.running), 32'd0);
        step(100);
        check("pause_hold", 32'(w_dw), 32'h0123);
        check("pause_running", 32'(if_wrap.running), 32'd0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("resume_running", 32'(if_wrap.running), 32'd1);
        check("resume_disp", 32'(w_dw), 32'h0123);
        step(1);
        check("resume_partial", 32'(w_dw), 32'h0124);

        // lap split and release
        reset = 1'b1; step(1); reset = 1'b0;
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        step(108);
        check("at_5_4", 32'(w_dw), 32'h0054);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check("lap1_valid", 32'(if_wrap.lap_valid), 32'd1);
        check("lap1_disp", 32'(w_dw), 32'h0054);
        step(39);
        check("lap1_hold", 32'(w_dw), 32'h0054);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check("lap2_valid", 32'(if_wrap.lap_valid), 32'd0);
        check("lap2_disp", 32'(w_dw), 32'h0074);
        // capture on a tick cycle holds the pre-increment value
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check("lap_tick_disp", 32'(w_dw), 32'h0074);
        check("lap_tick_valid", 32'(if_wrap.lap_valid), 32'd1);
        step(1);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check("lap_stop_disp", 32'(w_dw), 32'h0074);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check("pause_release", 32'(w_dw), 32'h0076);
        check("pause_release_v", 32'(if_wrap.lap_valid), 32'd0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check("clear_disp", 32'(w_dw), 32'h0000);
        check("clear_flags", 32'({if_wrap.running, if_wrap.overflow, if_wrap.lap_valid}), 32'd0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check("idle_lap_ignored", 32'(if_wrap.lap_valid), 32'd0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        step(2);
        check("restart_ms1", 32'(w_dw), 32'h0001);

        // simultaneous pulses
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        check("start_stop_pause", 32'(if_wrap.running), 32'd0);
        reset = 1'b1; if_wrap.lap = 1'b1;
        step(1);
        reset = 1'b0; if_wrap.lap = 1'b0;
        check("rst_lap_disp", 32'(w_dw), 32'h0000);
        check("rst_lap_flags", 32'({if_wrap.running, if_wrap.overflow, if_wrap.lap_valid}), 32'd0);

        // maximum time on both overflow policies
        pulse(1'b1, 1'b0, 1'b0, 1'b1);
        step(11998);
        check("max_wrap", 32'(w_dw), 32'h9599);
        check("max_sat", 32'(w_ds), 32'h9599);
        check("max_ovf0", 32'(if_wrap.overflow), 32'd0);
        step(2);
        check("wrap_disp", 32'(w_dw), 32'h0000);
        check("wrap_flags", 32'({if_wrap.running, if_wrap.overflow}), 32'b11);
        check("sat_disp", 32'(w_ds), 32'h9599);
        check("sat_flags", 32'({if_sat.running, if_sat.overflow}), 32'b01);
        step(2);
        check("wrap_continue", 32'(w_dw), 32'h0001);
        check("wrap_ovf_sticky", 32'(if_wrap.overflow), 32'd1);
        if_sat.start_resume = 1'b1;
        step(1);
        if_sat.start_resume = 1'b0;
        check("sat_resume_run", 32'(if_sat.running), 32'd1);
        step(2);
        check("sat_resume_hold", 32'(w_ds), 32'h9599);
        check("sat_repause", 32'(if_sat.running), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
